// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Direction-input front end for the Snake core. Each raw button is
//   synchronised (2 flops) and debounced; a debounced 0->1 transition becomes
//   a direction event. Events are filtered against the most recent direction
//   (queue tail, or the applied direction when the queue is empty) so that
//   repeats and reversals are rejected. Accepted events are queued, and one
//   queued direction is applied per game step.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset, clears all state
//   l, r, u, d   raw buttons (asynchronous, active-high)
//   step         one-cycle game-tick pulse, pops one queued direction
//   dir          applied direction (0 up, 1 right, 2 down, 3 left)
//   dir_changed  one-cycle pulse, dir was updated by the previous step
//   q_count      number of queued directions
//   drop         one-cycle pulse, a press event was discarded
module snake_dir_ctrl #(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter int          QUEUE_DEPTH     = 4,
   parameter logic [1:0]  INIT_DIR        = 2'd1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           l,
   input  logic                           r,
   input  logic                           u,
   input  logic                           d,
   input  logic                           step,
   output logic [1:0]                     dir,
   output logic                           dir_changed,
   output logic [$clog2(QUEUE_DEPTH):0]   q_count,
   output logic                           drop
);

   localparam int NUM_BTN = 4;
   localparam int DCW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW      = $clog2(QUEUE_DEPTH);
   localparam int CW      = PW + 1;

   // Button lane order doubles as the priority order: u > d > l > r.
   localparam logic [NUM_BTN-1:0][1:0] LANE_DIR = {2'd1, 2'd3, 2'd2, 2'd0};

   logic [NUM_BTN-1:0]          raw;
   logic [NUM_BTN-1:0]          sync1, sync2, deb, press;
   logic [NUM_BTN-1:0][DCW-1:0] cnt;

   assign raw = {r, l, d, u};

   // ---------------- synchroniser + debounce, one lane per button ----------
   // The counter holds the number of consecutive differing samples already
   // seen; the sample that would bring it to DEBOUNCE_CYCLES flips the level
   // instead. press is a registered pulse on a debounced rising flip.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         press <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NUM_BTN; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i]   <= '0;
               deb[i]   <= sync2[i];
               press[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---------------- event selection and acceptance ------------------------
   logic          ev;
   logic [1:0]    ev_dir;
   logic [1:0]    fifo [QUEUE_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [1:0]    ref_dir;
   logic          full, pop, push;

   always_comb begin
      ev     = 1'b0;
      ev_dir = 2'd0;
      // Walk from lowest to highest priority so the highest one wins.
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (press[i]) begin
            ev     = 1'b1;
            ev_dir = LANE_DIR[i];
         end
      end
   end

   // New events are compared to the last direction that will be in effect
   // before them: the queue tail if anything is queued, else dir.
   assign ref_dir = (q_count != '0) ? fifo[wptr - 1'b1] : dir;
   assign full    = (q_count == CW'(QUEUE_DEPTH));
   assign pop     = step && (q_count != '0);
   // A full queue still accepts when a pop frees a slot in the same cycle.
   assign push    = ev && (ev_dir != ref_dir) && (ev_dir != (ref_dir ^ 2'b10))
                    && (!full || pop);

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= ev_dir;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir         <= INIT_DIR;
         dir_changed <= 1'b0;
         drop        <= 1'b0;
         q_count     <= '0;
         wptr        <= '0;
         rptr        <= '0;
      end else begin
         dir_changed <= pop;
         drop        <= ev && !push;
         if (pop) begin
            dir  <= fifo[rptr];
            rptr <= rptr + 1'b1;
         end
         if (push) wptr <= wptr + 1'b1;
         q_count <= q_count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;
   localparam int         DB   = 4;
   localparam int         QD   = 4;
   localparam logic [1:0] INIT = 2'd1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btns = '0;       // [0]=u [1]=d [2]=l [3]=r
   logic       step = 1'b0;
   logic       u, d, l, r;
   logic [1:0] dir;
   logic       dir_changed, drop;
   logic [2:0] q_count;

   assign u = btns[0];
   assign d = btns[1];
   assign l = btns[2];
   assign r = btns[3];

   snake_dir_ctrl #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD), .INIT_DIR(INIT)) dut (
      .clk(clk), .reset(reset), .l(l), .r(r), .u(u), .d(d), .step(step),
      .dir(dir), .dir_changed(dir_changed), .q_count(q_count), .drop(drop));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_drop_seen = 0;

   // ---------------- behavioural reference model ---------------------------
   logic [1:0]  m_dir;
   bit          m_chg, m_drop;
   logic [1:0]  m_q[$];
   int unsigned rawh[4], synh[4];
   int          nraw[4], nsyn[4];
   bit          m_deb[4], m_ev[4];

   function automatic logic [1:0] dir_of(int i);
      case (i)
         0: return 2'd0;
         1: return 2'd2;
         2: return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   task automatic m_reset();
      m_dir = INIT; m_chg = 0; m_drop = 0; m_q.delete();
      for (int i = 0; i < 4; i++) begin
         rawh[i] = 0; synh[i] = 0; nraw[i] = 0; nsyn[i] = 0;
         m_deb[i] = 0; m_ev[i] = 0;
      end
   endtask

   // One clock edge: the event found on the previous edge is judged first,
   // then the button histories advance. A button level is accepted once the
   // last DB synchronised samples all disagree with the current level.
   task automatic m_edge();
      logic [3:0]  raw;
      bit          ev_any, pop, push, s;
      logic [1:0]  ev_dir, ref_d;
      int unsigned mask, inv;
      raw = btns; ev_any = 0; ev_dir = 0;
      for (int i = 3; i >= 0; i--)
         if (m_ev[i]) begin ev_any = 1; ev_dir = dir_of(i); end
      ref_d = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      pop   = step && (m_q.size() > 0);
      push  = ev_any && (ev_dir != ref_d) && (ev_dir != (ref_d ^ 2'b10))
              && ((m_q.size() < QD) || pop);
      m_drop = ev_any && !push;
      m_chg  = pop;
      if (pop)  m_dir = m_q.pop_front();
      if (push) m_q.push_back(ev_dir);
      mask = (1 << DB) - 1;
      for (int i = 0; i < 4; i++) begin
         rawh[i] = (rawh[i] << 1) | raw[i];
         if (nraw[i] < 100) nraw[i]++;
         s = (nraw[i] >= 3) ? rawh[i][2] : 1'b0;
         synh[i] = (synh[i] << 1) | s;
         if (nsyn[i] < 100) nsyn[i]++;
         m_ev[i] = 0;
         inv = m_deb[i] ? 32'hFFFF_FFFF : 32'h0;
         if (nsyn[i] >= DB && ((synh[i] ^ inv) & mask) == mask) begin
            m_deb[i] = !m_deb[i];
            m_ev[i]  = m_deb[i];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
      if (drop) n_drop_seen++;
   endtask

   task automatic press(int b, int hold, int gap);
      btns[b] = 1'b1;
      repeat (hold) tick();
      btns[b] = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      reset = 1'b0; m_reset();
      #12 reset = 1'b1;
      n_chk++; if (dir !== 2'd1) begin n_fail++; $display("FAIL reset_dir: got %0d want 1", dir); end
      n_chk++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q_count); end
      n_chk++; if (drop !== 1'b0 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got drop=%0d chg=%0d want 0 0", drop, dir_changed); end
      tick();
      pulse_step();
      n_chk++; if (dir !== 2'd1 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL empty_step: got dir=%0d chg=%0d want 1 0", dir, dir_changed); end
   endtask

   task automatic test_reject();
      n_drop_seen = 0;
      btns[0] = 1'b1;
      repeat (3) tick();
      btns[0] = 1'b0;
      repeat (10) tick();
      n_chk++; if (q_count !== 3'd0 || n_drop_seen != 0) begin n_fail++; $display("FAIL glitch: got q=%0d drops=%0d want 0 0", q_count, n_drop_seen); end
      press(2, 6, 8);
      n_chk++; if (q_count !== 3'd0 || n_drop_seen != 1) begin n_fail++; $display("FAIL reversal: got q=%0d drops=%0d want 0 1", q_count, n_drop_seen); end
      n_drop_seen = 0;
      press(3, 6, 8);
      n_chk++; if (q_count !== 3'd0 || n_drop_seen != 1) begin n_fail++; $display("FAIL repeat: got q=%0d drops=%0d want 0 1", q_count, n_drop_seen); end
   endtask

   task automatic test_single_press();
      btns[1] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 6) begin
            n_chk++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL latency_early: got q=%0d want 0", q_count); end
         end
         if (c == 7) begin
            n_chk++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL latency: got q=%0d want 1", q_count); end
         end
      end
      btns[1] = 1'b0;
      repeat (8) tick();
      pulse_step();
      n_chk++; if (dir !== 2'd2 || dir_changed !== 1'b1 || q_count !== 3'd0) begin n_fail++; $display("FAIL step_pop: got dir=%0d chg=%0d q=%0d want 2 1 0", dir, dir_changed, q_count); end
      tick();
      n_chk++; if (dir !== 2'd2 || dir_changed !== 1'b0) begin n_fail++; $display("FAIL chg_one_cycle: got dir=%0d chg=%0d want 2 0", dir, dir_changed); end
      // Back to right so the queue-fill sequence starts from dir=1.
      press(3, 6, 8);
      pulse_step();
      n_chk++; if (dir !== 2'd1) begin n_fail++; $display("FAIL restore_right: got %0d want 1", dir); end
   endtask

   task automatic test_fill();
      int         seq[5];
      logic [1:0] exp_dir[4];
      seq = '{1, 2, 0, 3, 1};
      exp_dir = '{2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 5; k++) begin
         n_drop_seen = 0;
         press(seq[k], 6, 8);
         if (k < 4) begin
            n_chk++; if (q_count !== 3'(k + 1) || n_drop_seen != 0) begin n_fail++; $display("FAIL fill_%0d: got q=%0d drops=%0d want %0d 0", k, q_count, n_drop_seen, k + 1); end
         end else begin
            n_chk++; if (q_count !== 3'd4 || n_drop_seen != 1) begin n_fail++; $display("FAIL full_drop: got q=%0d drops=%0d want 4 1", q_count, n_drop_seen); end
         end
      end
      for (int k = 0; k < 4; k++) begin
         pulse_step();
         n_chk++; if (dir !== exp_dir[k] || dir_changed !== 1'b1) begin n_fail++; $display("FAIL drain_%0d: got dir=%0d chg=%0d want %0d 1", k, dir, dir_changed, exp_dir[k]); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int seq[4];
      seq = '{1, 2, 0, 3};
      for (int k = 0; k < 4; k++) press(seq[k], 6, 8);
      n_chk++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL refill: got q=%0d want 4", q_count); end
      n_drop_seen = 0;
      btns[1] = 1'b1;
      repeat (6) tick();
      pulse_step();       // 7th edge: push of d coincides with the pop
      n_chk++; if (q_count !== 3'd4 || dir !== 2'd2 || dir_changed !== 1'b1 || drop !== 1'b0) begin n_fail++; $display("FAIL push_pop_full: got q=%0d dir=%0d chg=%0d drop=%0d want 4 2 1 0", q_count, dir, dir_changed, drop); end
      btns[1] = 1'b0;
      repeat (8) tick();
      n_chk++; if (n_drop_seen != 0) begin n_fail++; $display("FAIL push_pop_nodrop: got drops=%0d want 0", n_drop_seen); end
   endtask

   task automatic test_reset_mid();
      pulse_step();
      pulse_step();
      n_chk++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL pre_reset_q: got %0d want 2", q_count); end
      btns[0] = 1'b1;
      tick();
      #2 reset = 1'b0; m_reset();
      #1;
      n_chk++; if (dir !== 2'd1 || q_count !== 3'd0) begin n_fail++; $display("FAIL async_reset: got dir=%0d q=%0d want 1 0", dir, q_count); end
      #2 reset = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 6) begin
            n_chk++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL held_early: got q=%0d want 0", q_count); end
         end
      end
      n_chk++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL held_through_reset: got q=%0d want 1", q_count); end
      btns[0] = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_priority();
      pulse_step();       // dir becomes up
      n_drop_seen = 0;
      btns[2] = 1'b1; btns[3] = 1'b1;   // l and r together: l outranks r
      repeat (6) tick();
      btns = '0;
      repeat (8) tick();
      n_chk++; if (q_count !== 3'd1 || n_drop_seen != 0) begin n_fail++; $display("FAIL prio_queue: got q=%0d drops=%0d want 1 0", q_count, n_drop_seen); end
      pulse_step();
      n_chk++; if (dir !== 2'd3) begin n_fail++; $display("FAIL prio_dir: got %0d want 3", dir); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) btns[b] = ~btns[b];
         step = ($urandom_range(0, 9) == 0);
         tick();
         n_chk++; if (dir !== m_dir || dir_changed !== m_chg || drop !== m_drop || q_count !== 3'(m_q.size())) begin
            n_fail++;
            $display("FAIL rand_cycle_%0d: got dir=%0d chg=%0d drop=%0d q=%0d want %0d %0d %0d %0d",
                     c, dir, dir_changed, drop, q_count, m_dir, m_chg, m_drop, m_q.size());
         end
      end
      step = 1'b0;
      btns = '0;
   endtask

   initial begin
      test_reset();
      test_reject();
      test_single_press();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      test_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Parametrised direction-input front end for the Snake core: synchronises and debounces the four raw buttons (l, r, u, d), turns presses into direction events and queues them.
- Applies one queued direction per game step and rejects reversals and repeats.
- Replaces direct button-to-direction wiring so fast multi-press sequences between two steps are not lost.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk samples needed to accept a button level change (5 ms at 100 MHz); minimum 1.
- QUEUE_DEPTH, 4, direction FIFO entries; power of two, minimum 2.
- INIT_DIR, 2'd1, direction after reset (encoding: 0 up, 1 right, 2 down, 3 left).

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low; clears all state
- l  input  1  raw left button, asynchronous, active-high
- r  input  1  raw right button
- u  input  1  raw up button
- d  input  1  raw down button
- step  input  1  one-cycle pulse from game tick; consume one queued direction
- dir  output  2  current applied direction
- dir_changed  output  1  one-cycle pulse: dir updated by this step
- q_count  output  $clog2(QUEUE_DEPTH)+1  queued entries
- drop  output  1  one-cycle pulse: a press event was discarded

Behaviour:
- Reset (reset=0, async) sets:
  - dir=INIT_DIR
  - dir_changed=0, drop=0, q_count=0
  - synchronisers, debounce counters and debounced levels to 0
  - FIFO pointers to 0
- Synchroniser: 2-flop per button. Debounce and edge logic see only the synchronised level.
- Debounce, per button:
  - Counter increments while the synchronised level differs from the debounced level; it resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level is a press event.
  - Latency from raw edge to event: 2 + DEBOUNCE_CYCLES cycles.
- Simultaneous events in one cycle: only the highest-priority one is taken (u > d > l > r). The others are ignored, with no drop pulse.
- Reference direction for checking a new event = FIFO tail entry if q_count>0, else dir. Register values at cycle start are used.
- Event acceptance:
  - Event equal to the reference direction: discard, drop=1.
  - Event equal to the reference direction XOR 2'b10 (reversal): discard, drop=1.
  - Event arriving with the FIFO full and no pop this cycle: discard, drop=1.
  - Otherwise push.
- Step:
  - step=1 with q_count>0: pop the head; dir <= head next cycle; dir_changed=1 for that one cycle.
  - step=1 with the FIFO empty: dir unchanged, dir_changed=0.
- Pop and push in the same cycle:
  - Both are performed; q_count is unchanged.
  - A full FIFO accepts the push because the pop frees a slot.
  - A push into an empty FIFO coinciding with step is not applied until the next step (no bypass).
- Timing: dir, dir_changed, drop and q_count are registered, 1-cycle latency from the causing event or step.
- FIFO storage: 2-bit entries; read and write pointers wrap modulo QUEUE_DEPTH; q_count saturates at QUEUE_DEPTH by construction.
- Holding a button produces a single event. A new event needs release (debounced 0) and then a press again.
- Mid-operation reset: all queued entries are lost, dir returns to INIT_DIR, and a button held through reset release generates an event after DEBOUNCE_CYCLES+2 cycles.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4, INIT_DIR=1.
- Reset deassert, no input -> dir=1, q_count=0, drop=0. Pulse step -> dir stays 1, dir_changed=0.
- Press d for 10 cycles, then release -> q_count=1 exactly 7 cycles after the d rise (2 sync + 4 debounce + 1 register). Pulse step -> next cycle dir=2, dir_changed=1 for one cycle, q_count=0.
- Glitch u high for 3 cycles (shorter than the debounce) -> no event, q_count=0. Press l with dir=1 -> drop=1, q_count=0 (reversal). Press r -> drop=1 (repeat).
- With dir=1, press in order d, l, u, r, d, each held and released with no step -> accepted d (ref 1), l (ref 2), u (ref 3), r (ref 0), q_count=4. The fifth press d (ref 1, full) gives drop=1. Four steps -> dir sequence 2, 3, 0, 1.
- FIFO full, and d's debounced press event coincides with a step pulse -> pop (dir=2) and push both occur; q_count stays 4; no drop.
- Two entries queued, then assert reset=0 for 1 cycle asynchronously mid-clock -> dir=1 and q_count=0 immediately, without waiting for a clk edge. u held across reset release -> event queued 7 cycles after release, q_count=1.
